// File: rtl/panel_pkg.sv
// Shared types and default timing constants for the front-panel input conditioner.
// The default debounce window is derived from the board clock and the debounce time.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int SYS_CLK_HZ  = 27_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 27 MHz -> 270000 cycles
  localparam int DEFAULT_DEBOUNCE_CYCLES = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: synchroniser chain, debounce FSM with persistence counter,
// and registered level plus single-cycle rise/fall pulses.
module debounce_channel
  import panel_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;

  deb_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // Pulses are only produced on the acceptance cycle, so they default low.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    case (state_reg)
      IDLE_LOW: begin
        level_next = 1'b0;
        if (synced) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!synced) begin
          state_next = IDLE_LOW;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HIGH;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        level_next = 1'b1;
        if (!synced) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (synced) begin
          state_next = IDLE_HIGH;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LOW;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE_LOW;
      end
    endcase
  end

  assign level_out  = level_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: N_INPUTS independent debounce channels between the
// board pins and the CPU clock block's mode / manual_toggle / halt inputs.
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int N_INPUTS        = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] level_out,
  output logic [N_INPUTS-1:0] rise_pulse,
  output logic [N_INPUTS-1:0] fall_pulse
);

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .raw_in     (raw_in[gi]),
      .level_out  (level_out[gi]),
      .rise_pulse (rise_pulse[gi]),
      .fall_pulse (fall_pulse[gi])
    );
  end

endmodule
